rc4_key_search_engine: RTL and testbench

//  Parametrised RC4 engine: INIT, KSA and PRGA decrypt run under one FSM, iterated over a key range.
//  Per key: decrypts the message ROM into result RAM; in search mode, checks each byte as printable lowercase/space.
//  On the first passing key it stops and reports that key.

---
 rtl/rc4_key_search_engine_if.sv | 36 +++
 rtl/rc4_key_search_engine.sv | 198 +++++++++++++++++++
 tb/tb_rc4_key_search_engine.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_key_search_engine_if.sv
// Control, status and memory-port bundle for rc4_key_search_engine.
// The engine uses the master view; the surrounding top level (or bench) uses the slave view.
interface rc4_key_search_engine_if #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_AW    = 5
);
    logic                   start;
    logic                   search_en;
    logic [8*KEY_BYTES-1:0] key_lo;
    logic [8*KEY_BYTES-1:0] key_hi;
    logic [8*KEY_BYTES-1:0] key_out;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [7:0]             s_addr;
    logic [7:0]             s_data;
    logic                   s_wren;
    logic [7:0]             s_q;
    logic [MSG_AW-1:0]      rom_addr;
    logic [7:0]             rom_q;
    logic [MSG_AW-1:0]      res_addr;
    logic [7:0]             res_data;
    logic                   res_wren;

    modport master (
        input  start, search_en, key_lo, key_hi, s_q, rom_q,
        output key_out, busy, done, found, s_addr, s_data, s_wren,
               rom_addr, res_addr, res_data, res_wren
    );

    modport slave (
        output start, search_en, key_lo, key_hi, s_q, rom_q,
        input  key_out, busy, done, found, s_addr, s_data, s_wren,
               rom_addr, res_addr, res_data, res_wren
    );
endinterface

// File: rtl/rc4_key_search_engine.sv
// RC4 INIT/KSA/PRGA engine stepping through a key range until the decrypted message is
// all lowercase/space. Memories are sync-read: address in state X, data used two edges later.
module rc4_key_search_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rc4_key_search_engine_if.master bus
);
    localparam int KW = 8 * KEY_BYTES;

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT,
        ST_KSA_RI, ST_KSA_WI, ST_KSA_J, ST_KSA_WJ, ST_KSA_SW1, ST_KSA_SW2,
        ST_PR_I, ST_PR_WI, ST_PR_J, ST_PR_WJ, ST_PR_SW1, ST_PR_SW2,
        ST_PR_F, ST_PR_WF, ST_PR_X, ST_FINISH
    } state_t;

    typedef struct packed {
        state_t            state;
        logic [7:0]        i;
        logic [7:0]        j;
        logic [7:0]        si;
        logic [7:0]        sj;
        logic [7:0]        kidx;
        logic [MSG_AW-1:0] k;
        logic [KW-1:0]     key;
        logic [KW-1:0]     key_hi;
        logic              search;
        logic              pass;
        logic [7:0]        s_addr;
        logic [7:0]        s_data;
        logic              s_wren;
        logic [MSG_AW-1:0] rom_addr;
        logic [MSG_AW-1:0] res_addr;
        logic [7:0]        res_data;
        logic              res_wren;
        logic              busy;
        logic              done;
        logic              found;
    } regs_t;

    regs_t      r_q;
    regs_t      w_d;
    logic [7:0] w_key_byte;
    logic [7:0] w_plain;

    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // Key byte 0 is the most significant byte of the key.
    always_comb begin
        w_key_byte = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++)
            if (int'(r_q.kidx) == n) w_key_byte = r_q.key[8*(KEY_BYTES-1-n) +: 8];
    end

    assign w_plain = bus.s_q ^ bus.rom_q;

    // NOTE: reset_n is active-high despite its name; every register, outputs included, clears to zero.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) r_q <= '0;
        else         r_q <= w_d;  // NOTE: non-blocking for all sequential state
    end

    // NOTE: w_d starts as a copy of r_q so every field has a value on every path (no latches).
    always_comb begin
        w_d          = r_q;
        w_d.s_wren   = 1'b0;
        w_d.res_wren = 1'b0;
        unique case (r_q.state)
            ST_IDLE: if (bus.start) begin
                w_d.key    = bus.key_lo;
                w_d.key_hi = bus.key_hi;
                w_d.search = bus.search_en;
                w_d.busy   = 1'b1;
                w_d.done   = 1'b0;
                w_d.found  = 1'b0;
                w_d.i      = 8'd0;
                w_d.state  = ST_INIT;
            end
            ST_INIT: begin
                w_d.s_addr = r_q.i;
                w_d.s_data = r_q.i;
                w_d.s_wren = 1'b1;
                w_d.i      = r_q.i + 8'd1;
                if (r_q.i == 8'hFF) begin
                    w_d.j     = 8'd0;
                    w_d.kidx  = 8'd0;
                    w_d.state = ST_KSA_RI;
                end
            end
            ST_KSA_RI: begin
                w_d.s_addr = r_q.i;
                w_d.state  = ST_KSA_WI;
            end
            ST_KSA_WI: w_d.state = ST_KSA_J;
            ST_KSA_J: begin
                w_d.si     = bus.s_q;
                w_d.j      = r_q.j + bus.s_q + w_key_byte;
                w_d.s_addr = r_q.j + bus.s_q + w_key_byte;
                w_d.kidx   = (r_q.kidx == 8'(KEY_BYTES-1)) ? 8'd0 : r_q.kidx + 8'd1;
                w_d.state  = ST_KSA_WJ;
            end
            ST_KSA_WJ: w_d.state = ST_KSA_SW1;
            // Writing S[i] first then S[j]=old S[i] leaves S[i] intact when i==j.
            ST_KSA_SW1, ST_PR_SW1: begin
                w_d.sj     = bus.s_q;
                w_d.s_addr = r_q.i;
                w_d.s_data = bus.s_q;
                w_d.s_wren = 1'b1;
                w_d.state  = (r_q.state == ST_KSA_SW1) ? ST_KSA_SW2 : ST_PR_SW2;
            end
            ST_KSA_SW2: begin
                w_d.s_addr = r_q.j;
                w_d.s_data = r_q.si;
                w_d.s_wren = 1'b1;
                w_d.i      = r_q.i + 8'd1;
                if (r_q.i == 8'hFF) begin
                    w_d.j     = 8'd0;
                    w_d.k     = '0;
                    w_d.state = ST_PR_I;
                end else begin
                    w_d.state = ST_KSA_RI;
                end
            end
            ST_PR_I: begin
                w_d.i      = r_q.i + 8'd1;
                w_d.s_addr = r_q.i + 8'd1;
                w_d.state  = ST_PR_WI;
            end
            ST_PR_WI: w_d.state = ST_PR_J;
            ST_PR_J: begin
                w_d.si     = bus.s_q;
                w_d.j      = r_q.j + bus.s_q;
                w_d.s_addr = r_q.j + bus.s_q;
                w_d.state  = ST_PR_WJ;
            end
            ST_PR_WJ: w_d.state = ST_PR_SW1;
            ST_PR_SW2: begin
                w_d.s_addr = r_q.j;
                w_d.s_data = r_q.si;
                w_d.s_wren = 1'b1;
                w_d.state  = ST_PR_F;
            end
            ST_PR_F: begin
                w_d.s_addr   = r_q.si + r_q.sj;
                w_d.rom_addr = r_q.k;
                w_d.state    = ST_PR_WF;
            end
            ST_PR_WF: w_d.state = ST_PR_X;
            ST_PR_X: begin
                w_d.res_addr = r_q.k;
                w_d.res_data = w_plain;
                w_d.res_wren = 1'b1;
                if (r_q.search && !is_printable(w_plain)) begin
                    // A >= test also covers key_lo > key_hi: only key_lo is tried.
                    if (r_q.key >= r_q.key_hi) begin
                        w_d.pass  = 1'b0;
                        w_d.state = ST_FINISH;
                    end else begin
                        w_d.key   = r_q.key + 1'b1;
                        w_d.i     = 8'd0;
                        w_d.state = ST_INIT;
                    end
                end else if (r_q.k == MSG_AW'(MSG_LEN-1)) begin
                    w_d.pass  = 1'b1;
                    w_d.state = ST_FINISH;
                end else begin
                    w_d.k     = r_q.k + 1'b1;
                    w_d.state = ST_PR_I;
                end
            end
            ST_FINISH: begin
                w_d.busy  = 1'b0;
                w_d.done  = 1'b1;
                w_d.found = r_q.pass;
                w_d.state = ST_IDLE;
            end
            default: w_d.state = ST_IDLE;
        endcase
    end

    assign bus.key_out  = r_q.key;
    assign bus.busy     = r_q.busy;
    assign bus.done     = r_q.done;
    assign bus.found    = r_q.found;
    assign bus.s_addr   = r_q.s_addr;
    assign bus.s_data   = r_q.s_data;
    assign bus.s_wren   = r_q.s_wren;
    assign bus.rom_addr = r_q.rom_addr;
    assign bus.res_addr = r_q.res_addr;
    assign bus.res_data = r_q.res_data;
    assign bus.res_wren = r_q.res_wren;
endmodule

// File: tb/tb_rc4_key_search_engine.sv
// Bench for rc4_key_search_engine: RC4 reference model, sync-read memory models,
// result-RAM scoreboard, a vector table of key-range runs and a second 4-byte-key instance.
module tb_rc4_key_search_engine;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rc4_key_search_engine_if #(.KEY_BYTES(3), .MSG_AW(5)) bus0 ();
    rc4_key_search_engine_if #(.KEY_BYTES(4), .MSG_AW(4)) bus1 ();

    rc4_key_search_engine #(.KEY_BYTES(3), .MSG_LEN(32), .MSG_AW(5)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    rc4_key_search_engine #(.KEY_BYTES(4), .MSG_LEN(16), .MSG_AW(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    logic [7:0] smem0 [256];
    logic [7:0] rom0  [32];
    logic [7:0] smem1 [256];
    logic [7:0] rom1  [16];
    logic [7:0] res1  [16];

    always @(posedge clk) begin
        if (bus0.s_wren) smem0[bus0.s_addr] <= bus0.s_data;
        bus0.s_q   <= smem0[bus0.s_addr];
        bus0.rom_q <= rom0[bus0.rom_addr];
        if (bus1.s_wren) smem1[bus1.s_addr] <= bus1.s_data;
        bus1.s_q   <= smem1[bus1.s_addr];
        bus1.rom_q <= rom1[bus1.rom_addr];
        if (bus1.res_wren) res1[bus1.res_addr] <= bus1.res_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference RC4 keystream into ks[0..len-1].
    logic [7:0] ks [32];
    task automatic model_ks(input logic [31:0] key, input int kb, input int len);
        logic [7:0]  s [256];
        logic [7:0]  i, j, t;
        logic [31:0] sh;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            sh = key >> (8 * (kb - 1 - (n % kb)));
            j = j + s[n] + sh[7:0];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 8'd0; j = 8'd0;
        for (int n = 0; n < len; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            ks[n] = s[t];
        end
    endtask

    function automatic bit printable(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    // Scoreboard: every result-RAM write must match the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (bus0.res_wren) begin
            check("res0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("res0_write", {8'(bus0.res_addr), bus0.res_data}, {e.addr, e.data});
            end
        end
        if (bus1.res_wren) begin
            check("res1_expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("res1_write", {8'(bus1.res_addr), bus1.res_data}, {e.addr, e.data});
            end
        end
    end

    // Counts complete INIT passes: 256 back-to-back writes S[n]=n.
    int run0   = 0;
    int inits0 = 0;
    always @(negedge clk) begin
        if (bus0.s_wren && bus0.s_addr == bus0.s_data && bus0.s_addr == 8'(run0)) run0 = run0 + 1;
        else if (bus0.s_wren && bus0.s_addr == 8'h00 && bus0.s_data == 8'h00)   run0 = 1;
        else                                                                     run0 = 0;
        if (run0 == 256) begin
            inits0++;
            run0 = 0;
        end
    end

    task automatic push_expected0(input logic srch, input logic [23:0] lo, input logic [23:0] hi);
        logic [23:0] key;
        logic [7:0]  p;
        bit          stop;
        bit          fail;
        key  = lo;
        stop = 1'b0;
        while (!stop) begin
            model_ks(32'(key), 3, 32);
            fail = 1'b0;
            for (int n = 0; n < 32; n++) begin
                if (!fail) begin
                    p = ks[n] ^ rom0[n];
                    q0.push_back('{8'(n), p});
                    if (srch && !printable(p)) fail = 1'b1;
                end
            end
            if (!fail || key >= hi) stop = 1'b1;
            else                    key  = key + 24'd1;
        end
    endtask

    task automatic wait_inits(input int target);
        int cyc;
        cyc = 0;
        while (inits0 < target && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("init_pass_seen", inits0 >= target, 1);
    endtask

    typedef struct {
        logic        srch;
        logic [23:0] lo;
        logic [23:0] hi;
        logic        exp_found;
        logic [23:0] exp_key;
        int          exp_inits;
        bit          glitch;
    } vec_t;
    vec_t vecs [5];

    task automatic run0_vec(input vec_t v);
        int cyc;
        push_expected0(v.srch, v.lo, v.hi);
        inits0 = 0;
        @(posedge clk); #1;
        bus0.search_en = v.srch;
        bus0.key_lo    = v.lo;
        bus0.key_hi    = v.hi;
        bus0.start     = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        check("busy_after_start", bus0.busy, 1);
        check("done_cleared", bus0.done, 0);
        if (v.glitch) begin
            // A start during KSA with a different key_lo must be ignored.
            wait_inits(1);
            repeat (100) @(posedge clk);
            #1;
            bus0.key_lo = 24'h000000;
            bus0.start  = 1'b1;
            @(posedge clk); #1;
            bus0.start  = 1'b0;
            bus0.key_lo = v.lo;
        end
        cyc = 0;
        while (!bus0.done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done", bus0.done, 1);
        check("busy_end", bus0.busy, 0);
        check("found", bus0.found, v.exp_found);
        check("key_out", bus0.key_out, v.exp_key);
        check("init_passes", inits0, v.exp_inits);
        check("res0_all_seen", q0.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", bus0.done, 1);
        check("key_out_hold", bus0.key_out, v.exp_key);
        q0.delete();
    endtask

    initial begin
        string       msg;
        logic [31:0] key1;
        logic [7:0]  exp1 [16];
        int          cyc;

        msg = "the quick brown fox jumps over z";
        model_ks(32'h000003, 3, 32);
        for (int n = 0; n < 32; n++) rom0[n] = ks[n] ^ msg[n];

        vecs[0] = '{1'b0, 24'h000000, 24'h000000, 1'b1, 24'h000000, 1, 1'b0};
        vecs[1] = '{1'b1, 24'h000000, 24'h000005, 1'b1, 24'h000003, 4, 1'b0};
        vecs[2] = '{1'b1, 24'h000004, 24'h000006, 1'b0, 24'h000006, 3, 1'b0};
        vecs[3] = '{1'b1, 24'h000003, 24'h000003, 1'b1, 24'h000003, 1, 1'b1};
        vecs[4] = '{1'b1, 24'h000005, 24'h000002, 1'b0, 24'h000005, 1, 1'b0};

        reset_n        = 1'b1;
        bus0.start     = 1'b0;
        bus0.search_en = 1'b0;
        bus0.key_lo    = '0;
        bus0.key_hi    = '0;
        bus1.start     = 1'b0;
        bus1.search_en = 1'b0;
        bus1.key_lo    = '0;
        bus1.key_hi    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_found", bus0.found, 0);
        check("rst_key_out", bus0.key_out, 0);
        check("rst_s_wren", bus0.s_wren, 0);
        check("rst_res_wren", bus0.res_wren, 0);
        #3 reset_n = 1'b0;

        // Abort a run in the middle of KSA.
        inits0 = 0;
        @(posedge clk); #1;
        bus0.search_en = 1'b1;
        bus0.key_lo    = 24'h000000;
        bus0.key_hi    = 24'h000005;
        bus0.start     = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        wait_inits(1);
        repeat (50) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("abort_busy", bus0.busy, 0);
        check("abort_done", bus0.done, 0);
        check("abort_found", bus0.found, 0);
        @(posedge clk); #1;
        check("abort_s_wren", bus0.s_wren, 0);
        #2 reset_n = 1'b0;
        check("abort_no_res", q0.size(), 0);

        for (int v = 0; v < 5; v++) run0_vec(vecs[v]);

        // 4-byte key, 16-byte message, random key and ciphertext.
        key1 = $urandom();
        for (int n = 0; n < 16; n++) rom1[n] = 8'($urandom_range(255));
        model_ks(key1, 4, 16);
        for (int n = 0; n < 16; n++) begin
            exp1[n] = ks[n] ^ rom1[n];
            q1.push_back('{8'(n), exp1[n]});
        end
        @(posedge clk); #1;
        bus1.search_en = 1'b0;
        bus1.key_lo    = key1;
        bus1.key_hi    = key1;
        bus1.start     = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        cyc = 0;
        while (!bus1.done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("k4_done", bus1.done, 1);
        check("k4_found", bus1.found, 1);
        check("k4_key_out", bus1.key_out, key1);
        check("k4_res_all_seen", q1.size(), 0);
        @(posedge clk); #1;
        for (int n = 0; n < 16; n++) check($sformatf("k4_ram[%0d]", n), res1[n], exp1[n]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
